// File: rtl/led_fade_pwm.sv
// LED fade driver: registers the upstream on/off request and ramps a PWM duty
// between 0 and full scale, one LSB per prescaler tick, instead of hard-switching.
module led_fade_pwm #(
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 390625
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_req,
  input  logic                enable,
  output logic                pwm_out,
  output logic [PWM_BITS-1:0] duty,
  output logic                busy
);

  localparam logic [PWM_BITS-1:0] MAX = {PWM_BITS{1'b1}};
  localparam int PRESC_W = $clog2(STEP_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(STEP_DIV - 1);

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RISE = 2'd1;
  localparam logic [1:0] ST_ON   = 2'd2;
  localparam logic [1:0] ST_FALL = 2'd3;

  logic [1:0]          state_q, state_d;
  logic                req_q, req_d;
  logic [PWM_BITS-1:0] duty_q, duty_d;
  logic [PWM_BITS-1:0] duty_act_q, duty_act_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                pwm_out_q, pwm_out_d;
  logic                tick;
  logic                ramping, ramping_next;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    req_d      = led_req;
    state_d    = state_q;
    duty_d     = duty_q;
    tick       = (presc_q == PRESC_LAST);

    // Reversal has priority over the end-of-ramp test, which has priority over a step,
    // so duty saturates at 0 and MAX without any explicit clamp.
    case (state_q)
      ST_OFF:  if (req_q) state_d = ST_RISE;
      ST_RISE: begin
        if (!req_q)              state_d = ST_FALL;
        else if (duty_q == MAX)  state_d = ST_ON;
        else if (tick)           duty_d  = duty_q + 1'b1;
      end
      ST_ON:   if (!req_q) state_d = ST_FALL;
      ST_FALL: begin
        if (req_q)               state_d = ST_RISE;
        else if (duty_q == '0)   state_d = ST_OFF;
        else if (tick)           duty_d  = duty_q - 1'b1;
      end
      default: state_d = ST_OFF;
    endcase

    // Prescaler runs uninterrupted across RISE<->FALL reversals and idles at 0 otherwise.
    ramping      = (state_q == ST_RISE) || (state_q == ST_FALL);
    ramping_next = (state_d == ST_RISE) || (state_d == ST_FALL);
    if (ramping && ramping_next) presc_d = tick ? '0 : presc_q + 1'b1;
    else                         presc_d = '0;

    // Duty is only sampled at the period boundary so a period is never truncated.
    pwm_cnt_d  = pwm_cnt_q + 1'b1;
    duty_act_d = (pwm_cnt_q == MAX) ? duty_q : duty_act_q;
    pwm_out_d  = enable & ((duty_act_q == MAX) | (pwm_cnt_q < duty_act_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      req_q      <= 1'b0;
      duty_q     <= '0;
      duty_act_q <= '0;
      pwm_cnt_q  <= '0;
      presc_q    <= '0;
      pwm_out_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      req_q      <= req_d;
      duty_q     <= duty_d;
      duty_act_q <= duty_act_d;
      pwm_cnt_q  <= pwm_cnt_d;
      presc_q    <= presc_d;
      pwm_out_q  <= pwm_out_d;
    end
  end

  assign pwm_out = pwm_out_q;
  assign duty    = duty_q;
  assign busy    = (state_q == ST_RISE) || (state_q == ST_FALL);

endmodule

// File: tb/tb_led_fade_pwm.sv
// Scoreboard bench for led_fade_pwm (PWM_BITS=4, STEP_DIV=4): stimulus queues
// cycle-stamped expectations, a monitor compares them on the falling edge.
module tb_led_fade_pwm;
  localparam int PW = 4;
  localparam int SD = 4;

  typedef enum {SIG_DUTY, SIG_PWM, SIG_BUSY} sig_e;
  typedef struct {
    int    cyc;
    sig_e  sig;
    int    exp;
    string name;
  } exp_t;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic          led_req = 1'b0;
  logic          enable  = 1'b1;
  logic          pwm_out;
  logic [PW-1:0] duty;
  logic          busy;

  logic clk_en  = 1'b1;
  logic probe   = 1'b0;
  int   cyc_cnt = 0;
  int   rel_cyc = 0;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];

  led_fade_pwm #(.PWM_BITS(PW), .STEP_DIV(SD)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .led_req (led_req),
    .enable  (enable),
    .pwm_out (pwm_out),
    .duty    (duty),
    .busy    (busy)
  );

  // Gated clock so the asynchronous reset can be exercised with no edges at all.
  initial forever begin
    #5;
    if (clk_en) clk = ~clk;
  end

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic expect_at(input int c, input sig_e s, input int v, input string nm);
    exp_t e;
    int   i;
    e.cyc = c; e.sig = s; e.exp = v; e.name = nm;
    i = sb.size();
    while (i > 0 && sb[i-1].cyc > c) i--;
    sb.insert(i, e);
  endtask

  task automatic wait_until(input int c);
    while (cyc_cnt < c) @(negedge clk);
  endtask

  function automatic int pcnt(input int n);
    return ((n - rel_cyc) % 16 + 16) % 16;
  endfunction

  task automatic pulse_probe();
    #1 probe = 1'b1;
    #1 probe = 1'b0;
  endtask

  // Monitor: compares every expectation due at the current cycle count.
  initial begin
    exp_t e;
    int   act;
    forever begin
      @(negedge clk or posedge probe);
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
        e = sb.pop_front();
        case (e.sig)
          SIG_DUTY: act = int'(duty);
          SIG_PWM:  act = int'(pwm_out);
          default:  act = int'(busy);
        endcase
        if (e.cyc < cyc_cnt) act = -1;
        check($sformatf("%s@%0d", e.name, e.cyc), act, e.exp);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g, b, a1, e1, bnd, n, f, r, e2, a;

    // Reset state while the clock runs
    expect_at(1, SIG_DUTY, 0, "rst_duty");
    expect_at(1, SIG_PWM,  0, "rst_pwm");
    expect_at(1, SIG_BUSY, 0, "rst_busy");
    expect_at(2, SIG_BUSY, 0, "rst_busy");
    wait_until(3);
    rst_n   = 1'b1;
    rel_cyc = cyc_cnt;

    // One-cycle request pulse: RISE then FALL with no step, back to OFF
    g = cyc_cnt + 2;
    expect_at(g + 1, SIG_BUSY, 0, "glitch_busy");
    expect_at(g + 2, SIG_BUSY, 1, "glitch_busy");
    expect_at(g + 3, SIG_BUSY, 1, "glitch_busy");
    expect_at(g + 4, SIG_BUSY, 0, "glitch_busy");
    expect_at(g + 6, SIG_BUSY, 0, "glitch_busy");
    for (int k = 2; k <= 5; k++) expect_at(g + k, SIG_DUTY, 0, "glitch_duty");
    for (int k = 1; k <= 20; k++) expect_at(g + k, SIG_PWM, 0, "glitch_pwm");
    wait_until(g);     led_req = 1'b1;
    wait_until(g + 1); led_req = 1'b0;
    wait_until(g + 22);

    // Asynchronous reset mid-RISE with the clock stopped
    b = cyc_cnt + 2;
    expect_at(b + 2,  SIG_BUSY, 1, "arst_pre_busy");
    expect_at(b + 10, SIG_DUTY, 2, "arst_pre_duty");
    expect_at(b + 11, SIG_BUSY, 1, "arst_pre_busy");
    wait_until(b); led_req = 1'b1;
    wait_until(b + 12);
    clk_en = 1'b0;
    #3 rst_n = 1'b0;
    expect_at(cyc_cnt, SIG_DUTY, 0, "arst_duty");
    expect_at(cyc_cnt, SIG_BUSY, 0, "arst_busy");
    expect_at(cyc_cnt, SIG_PWM,  0, "arst_pwm");
    pulse_probe();
    led_req = 1'b0;
    #2 rst_n = 1'b1;
    expect_at(cyc_cnt, SIG_DUTY, 0, "arst_rel_duty");
    expect_at(cyc_cnt, SIG_BUSY, 0, "arst_rel_busy");
    pulse_probe();
    rel_cyc = cyc_cnt;
    for (int k = 1; k <= 6; k++) begin
      expect_at(rel_cyc + k, SIG_BUSY, 0, "arst_off_busy");
      expect_at(rel_cyc + k, SIG_DUTY, 0, "arst_off_duty");
    end
    clk_en = 1'b1;
    wait_until(rel_cyc + 8);

    // Full rise to ON, then constant-high PWM from the following period
    a1 = cyc_cnt + 2;
    e1 = a1 + 2;
    expect_at(a1 + 1,  SIG_BUSY, 0,  "rise_busy");
    expect_at(e1,      SIG_BUSY, 1,  "rise_busy");
    expect_at(e1 + 3,  SIG_DUTY, 0,  "rise_duty");
    expect_at(e1 + 4,  SIG_DUTY, 1,  "rise_duty");
    expect_at(e1 + 7,  SIG_DUTY, 1,  "rise_duty");
    expect_at(e1 + 8,  SIG_DUTY, 2,  "rise_duty");
    expect_at(e1 + 59, SIG_DUTY, 14, "rise_duty");
    expect_at(e1 + 60, SIG_DUTY, 15, "rise_duty");
    expect_at(e1 + 60, SIG_BUSY, 1,  "rise_busy");
    expect_at(e1 + 61, SIG_BUSY, 0,  "on_busy");
    expect_at(e1 + 61, SIG_DUTY, 15, "on_duty");
    bnd = e1 + 61;
    while (pcnt(bnd) != 0) bnd++;
    for (int k = 1; k <= 16; k++) expect_at(bnd + k, SIG_PWM, 1, "on_pwm");
    wait_until(a1); led_req = 1'b1;
    wait_until(bnd + 17);

    // Enable gating while ON
    n = cyc_cnt + 2;
    expect_at(n,     SIG_PWM,  1,  "en_pwm");
    expect_at(n + 1, SIG_PWM,  0,  "en_pwm");
    expect_at(n + 3, SIG_PWM,  0,  "en_pwm");
    expect_at(n + 3, SIG_DUTY, 15, "en_duty");
    expect_at(n + 3, SIG_BUSY, 0,  "en_busy");
    expect_at(n + 4, SIG_PWM,  0,  "en_pwm");
    expect_at(n + 5, SIG_PWM,  1,  "en_pwm");
    expect_at(n + 8, SIG_PWM,  1,  "en_pwm");
    wait_until(n);     enable = 1'b0;
    wait_until(n + 4); enable = 1'b1;
    wait_until(n + 9);

    // Full fall from ON to OFF
    f = cyc_cnt + 2;
    expect_at(f + 1,  SIG_BUSY, 0,  "fall_busy");
    expect_at(f + 2,  SIG_BUSY, 1,  "fall_busy");
    expect_at(f + 5,  SIG_DUTY, 15, "fall_duty");
    expect_at(f + 6,  SIG_DUTY, 14, "fall_duty");
    expect_at(f + 30, SIG_DUTY, 8,  "fall_duty");
    expect_at(f + 62, SIG_DUTY, 0,  "fall_duty");
    expect_at(f + 62, SIG_BUSY, 1,  "fall_busy");
    expect_at(f + 63, SIG_BUSY, 0,  "off_busy");
    wait_until(f); led_req = 1'b0;
    wait_until(f + 64);

    // Reversal at duty 7: prescaler phase carries into FALL
    r  = cyc_cnt + 2;
    e2 = r + 2;
    expect_at(e2 + 27, SIG_DUTY, 6, "rev_duty");
    expect_at(e2 + 28, SIG_DUTY, 7, "rev_duty");
    expect_at(e2 + 29, SIG_BUSY, 1, "rev_busy");
    expect_at(e2 + 30, SIG_BUSY, 1, "rev_busy");
    expect_at(e2 + 31, SIG_DUTY, 7, "rev_duty");
    expect_at(e2 + 32, SIG_DUTY, 6, "rev_duty");
    expect_at(e2 + 36, SIG_DUTY, 5, "rev_duty");
    expect_at(e2 + 55, SIG_DUTY, 1, "rev_duty");
    expect_at(e2 + 56, SIG_DUTY, 0, "rev_duty");
    expect_at(e2 + 56, SIG_BUSY, 1, "rev_busy");
    expect_at(e2 + 57, SIG_BUSY, 0, "rev_busy");
    wait_until(r);       led_req = 1'b1;
    wait_until(e2 + 28); led_req = 1'b0;
    wait_until(e2 + 60);

    // PWM shape: a request toggling every cycle freezes duty; 5 -> 6 lands mid-period
    a = cyc_cnt + 2;
    while (pcnt(a) != 0) a++;
    expect_at(a + 22, SIG_DUTY, 5, "shape_duty");
    expect_at(a + 40, SIG_DUTY, 5, "shape_duty");
    expect_at(a + 65, SIG_DUTY, 5, "shape_duty");
    expect_at(a + 66, SIG_DUTY, 6, "shape_duty");
    expect_at(a + 96, SIG_DUTY, 6, "shape_duty");
    for (int i = 0; i < 64; i++)
      expect_at(a + 33 + i, SIG_PWM, ((i % 16) < ((i >= 48) ? 6 : 5)) ? 1 : 0,
                $sformatf("shape_pwm_k%0d", i % 16));
    expect_at(a + 140, SIG_BUSY, 0, "shape_end_busy");
    expect_at(a + 140, SIG_DUTY, 0, "shape_end_duty");
    expect_at(a + 160, SIG_PWM,  0, "shape_end_pwm");
    wait_until(a); led_req = 1'b1;
    for (int j = 0; j < 76; j++) begin
      wait_until(a + 22 + j);
      led_req = ((j % 2) == 1) || (j == 42);
    end
    wait_until(a + 98); led_req = 1'b0;
    wait_until(a + 162);

    repeat (2) @(negedge clk);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check($sformatf("%s@%0d_unreached", e.name, e.cyc), -1, e.exp);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
